// File: rtl/mem_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: size
// encodings, FSM states and the load extension helpers.
package mem_byte_sequencer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Number of memory byte cycles for a size code; the illegal code maps to
  // 1 so range arithmetic stays sane (it is rejected separately).
  function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd1;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend the low byte/half of an assembled load value.
  function automatic logic [31:0] extend_load(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {{24{sgn & data[7]}},  data[7:0]};
      SIZE_HALF: r = {{16{sgn & data[15]}}, data[15:0]};
      default:   r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer_load_extend.sv
// Combinational sign/zero extension of an assembled byte/half/word load.
// Kept as its own block so an I/O load path can reuse it.
module mem_load_extend
  import mem_byte_sequencer_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  // Pure function of the inputs; no state.
  always_comb begin
    ext = extend_load(data, size, sgn);
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Memory-access stage in front of a byte-wide memory. One load/store is
// split into 1, 2 or 4 big-endian byte cycles (MSB at the lowest address).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. req_ready is high only in IDLE; once resp_valid rises the
// response fields hold until resp_valid && resp_ready. Inputs are ignored
// outside IDLE, and no request is taken in the cycle a response retires.
module mem_byte_sequencer
  import mem_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 131072
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_wordaddr,
  output logic [7:0]        mem_writeData,
  output logic              mem_writeEnable,
  input  logic [7:0]        mem_readData,
  output state_t            dbg_state
);

  state_t        state;
  logic          wr_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [31:0]   wdata_q;
  logic [2:0]    n_q;
  logic [2:0]    k_q;
  logic [31:0]   shift_q;

  logic [2:0]    req_n;
  logic [ADDR_W:0] req_last_addr;
  logic          req_bad;
  logic [31:0]   shift_next;
  logic [31:0]   ext_data;
  logic          last_byte;
  logic [1:0]    next_idx;

  // Select byte idx of a right-aligned word (idx 0 = least significant).
  function automatic logic [7:0] pick_byte(input logic [31:0] d,
                                           input logic [1:0]  idx);
    return d[8*idx +: 8];
  endfunction

  // Request decode: byte count, alignment and range check. The range sum is
  // one bit wider than the address so a wrapping request is also caught.
  always_comb begin
    req_n         = bytes_for_size(req_size);
    req_last_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);
    req_bad       = (req_size == 2'd3) ||
                    ((req_size == SIZE_HALF) && req_addr[0]) ||
                    ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) ||
                    (req_last_addr >= (ADDR_W+1)'(MEM_BYTES));
  end

  // Per-byte datapath helpers for the ACCESS state.
  always_comb begin
    shift_next = {shift_q[23:0], mem_readData};
    last_byte  = (k_q == (n_q - 3'd1));
    next_idx   = 2'(n_q - 3'd2 - k_q);
  end

  mem_load_extend u_extend (
    .data (shift_next),
    .size (size_q),
    .sgn  (sgn_q),
    .ext  (ext_data)
  );

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  // Sequencer FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_q            <= 1'b0;
      size_q          <= SIZE_BYTE;
      sgn_q           <= 1'b0;
      wdata_q         <= '0;
      n_q             <= 3'd1;
      k_q             <= '0;
      shift_q         <= '0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
      mem_wordaddr    <= '0;
      mem_writeData   <= '0;
      mem_writeEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wdata_q <= req_wdata;
            n_q     <= req_n;
            k_q     <= '0;
            shift_q <= '0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state           <= ACCESS;
              mem_wordaddr    <= req_addr;
              mem_writeEnable <= req_write;
              mem_writeData   <= req_write ? pick_byte(req_wdata, 2'(req_n - 3'd1))
                                           : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            shift_q <= shift_next;
          end
          if (last_byte) begin
            state           <= RESP;
            mem_writeEnable <= 1'b0;
            mem_writeData   <= 8'h00;
            resp_valid      <= 1'b1;
            resp_err        <= 1'b0;
            resp_rdata      <= wr_q ? 32'h0 : ext_data;
          end else begin
            k_q           <= k_q + 3'd1;
            mem_wordaddr  <= mem_wordaddr + ADDR_W'(1);
            mem_writeData <= wr_q ? pick_byte(wdata_q, next_idx) : 8'h00;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a behavioural byte memory.
module tb_mem_byte_sequencer;
  import mem_byte_sequencer_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 131072;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_wordaddr;
  logic [7:0]        mem_writeData;
  logic              mem_writeEnable;
  logic [7:0]        mem_readData;
  state_t            dbg_state;

  logic [7:0]  mem [0:MEM_BYTES-1];
  int          we_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [32:0] exp_q[$];

  mem_byte_sequencer #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_wordaddr    (mem_wordaddr),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .mem_readData    (mem_readData),
    .dbg_state       (dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_readData = mem[mem_wordaddr[16:0]];

  always @(posedge clk) begin
    if (mem_writeEnable) begin
      mem[mem_wordaddr[16:0]] <= mem_writeData;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one request, wait for its response, compare against the scoreboard,
  // optionally stall the consumer for `hold` cycles, then retire it.
  task automatic issue(input string tag, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int hold);
    int lat;
    logic [32:0] exp;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = exp_q.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp[31:0]);
    chk({tag, ".err"}, 32'(resp_err), 32'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_BYTE;
        req_addr = 32'h300; req_wdata = 32'h55;
      end
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, exp[31:0]);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".retired"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int we_before;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;

    // reset block
    repeat (3) @(posedge clk);
    #1;
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.mem_we", 32'(mem_writeEnable), 32'd0);
    chk("rst.mem_addr", mem_wordaddr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    // word store then load
    we_before = we_cnt;
    issue("st_word", 1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5, 0);
    chk("st_word.we_cycles", 32'(we_cnt - we_before), 32'd4);
    chk("st_word.m100", 32'(mem[32'h100]), 32'hDE);
    chk("st_word.m101", 32'(mem[32'h101]), 32'hAD);
    chk("st_word.m102", 32'(mem[32'h102]), 32'hBE);
    chk("st_word.m103", 32'(mem[32'h103]), 32'hEF);
    issue("ld_word", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0);

    // half store, signed/unsigned loads, byte load
    issue("st_half", 1'b1, SIZE_HALF, 1'b0, 32'h202, 32'h000080F0, 32'h0, 1'b0, 3, 0);
    chk("st_half.m202", 32'(mem[32'h202]), 32'h80);
    chk("st_half.m203", 32'(mem[32'h203]), 32'hF0);
    issue("ld_half_s", 1'b0, SIZE_HALF, 1'b1, 32'h202, 32'h0, 32'hFFFF80F0, 1'b0, 3, 0);
    issue("ld_half_u", 1'b0, SIZE_HALF, 1'b0, 32'h202, 32'h0, 32'h000080F0, 1'b0, 3, 0);
    issue("ld_byte_s", 1'b0, SIZE_BYTE, 1'b1, 32'h203, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 0);
    issue("ld_byte_u", 1'b0, SIZE_BYTE, 1'b0, 32'h202, 32'h0, 32'h00000080, 1'b0, 2, 0);

    // error cases: no memory cycles at all
    we_before = we_cnt;
    issue("err_word", 1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("err_half", 1'b1, SIZE_HALF, 1'b0, 32'h3, 32'h1234, 32'h0, 1'b1, 1, 0);
    issue("err_size", 1'b1, 2'd3, 1'b0, 32'h0, 32'h1234, 32'h0, 1'b1, 1, 0);
    chk("err.no_writes", 32'(we_cnt - we_before), 32'd0);
    chk("err.mem3", 32'(mem[3]), 32'h00);

    // end-of-memory boundaries
    issue("st_top", 1'b1, SIZE_WORD, 1'b0, MEM_BYTES - 4, 32'h01020304, 32'h0, 1'b0, 5, 0);
    issue("ld_top", 1'b0, SIZE_WORD, 1'b0, MEM_BYTES - 4, 32'h0, 32'h01020304, 1'b0, 5, 0);
    issue("err_past", 1'b0, SIZE_WORD, 1'b0, MEM_BYTES - 2, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("ld_last", 1'b0, SIZE_BYTE, 1'b0, MEM_BYTES - 1, 32'h0, 32'h00000004, 1'b0, 2, 0);
    issue("err_wrap", 1'b0, SIZE_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 0);

    // consumer back-pressure with a stray request during the stall
    we_before = we_cnt;
    issue("hold", 1'b0, SIZE_HALF, 1'b0, 32'h100, 32'h0, 32'h0000DEAD, 1'b0, 3, 5);
    chk("hold.no_stray_write", 32'(we_cnt - we_before), 32'd0);
    chk("hold.m300", 32'(mem[32'h300]), 32'h00);

    // reset in the middle of a word store
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort.pre_we", 32'(mem_writeEnable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.we", 32'(mem_writeEnable), 32'd0);
    chk("abort.addr", mem_wordaddr, 32'd0);
    chk("abort.wdata", 32'(mem_writeData), 32'd0);
    chk("abort.state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    chk("abort.m40", 32'(mem[32'h40]), 32'hAA);
    chk("abort.m41", 32'(mem[32'h41]), 32'hBB);
    chk("abort.m42", 32'(mem[32'h42]), 32'h00);
    chk("abort.m43", 32'(mem[32'h43]), 32'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue("post_rst", 1'b0, SIZE_HALF, 1'b1, 32'h40, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0);

    chk("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
